// File: rtl/hanoi_move_gen.sv
// Optimal Towers of Hanoi move sequencer: emits 2^S-1 fr/to/disk moves, rod0 -> rod2.
// Define HANOI_MOVEGEN_SVA_EN to compile in the concurrent assertions and cover.
module hanoi_move_gen #(
  parameter int S = 4,
  localparam int DW = $clog2(S)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          move_ready,
  output logic          move_valid,
  output logic [1:0]    fr,
  output logic [1:0]    to,
  output logic [DW-1:0] disk,
  output logic [S-1:0]  move_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OFFER,
    DONE
  } state_t;

  localparam logic [S-1:0] ALL  = '1;
  localparam logic [S-1:0] PEN  = {{(S-1){1'b1}}, 1'b0};
  localparam logic [S-1:0] ONE  = {{(S-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_next;
  logic [S-1:0]  r_r0, r_r1, r_r2;
  logic [1:0]    r_fr, r_to;
  logic [DW-1:0] r_disk;
  logic [S-1:0]  r_cnt;

  logic          w_load, w_calc, w_hs;
  logic [S-1:0]  w_mask;
  logic [1:0]    w_p0, w_a, w_b;
  logic [S-1:0]  w_va, w_vb;
  logic [1:0]    w_fr, w_to;
  logic [DW-1:0] w_disk;

  function automatic logic [DW-1:0] top_idx(input logic [S-1:0] v);
    top_idx = '0;
    for (int i = S - 1; i >= 0; i--)
      if (v[i]) top_idx = DW'(i);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    move_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next = CALC;
      CALC: begin
        busy   = 1'b1;
        w_next = OFFER;
      end
      OFFER: begin
        busy       = 1'b1;
        move_valid = 1'b1;
        if (move_ready)
          w_next = (r_cnt == PEN) ? DONE : CALC;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_next = CALC;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_load = start && (r_state == IDLE || r_state == DONE);
  assign w_calc = (r_state == CALC);
  assign w_hs   = (r_state == OFFER) && move_ready;
  assign w_mask = ONE << r_disk;

  // Odd moves: the one legal move between the two rods not holding disk 0.
  always_comb begin
    w_p0   = r_r0[0] ? 2'd0 : (r_r1[0] ? 2'd1 : 2'd2);
    w_a    = 2'd1;
    w_b    = 2'd2;
    w_va   = r_r1;
    w_vb   = r_r2;
    w_fr   = w_p0;
    w_to   = 2'd0;
    w_disk = '0;
    unique case (w_p0)
      2'd0: begin
        w_a = 2'd1; w_b = 2'd2;
        w_va = r_r1; w_vb = r_r2;
      end
      2'd1: begin
        w_a = 2'd0; w_b = 2'd2;
        w_va = r_r0; w_vb = r_r2;
      end
      default: begin
        w_a = 2'd0; w_b = 2'd1;
        w_va = r_r0; w_vb = r_r1;
      end
    endcase
    if (!r_cnt[0]) begin
      w_fr = w_p0;
      if (S % 2 == 0)
        w_to = (w_p0 == 2'd2) ? 2'd0 : w_p0 + 2'd1;
      else
        w_to = (w_p0 == 2'd0) ? 2'd2 : w_p0 - 2'd1;
    end else if (w_vb == '0 ||
                 (w_va != '0 && top_idx(w_va) < top_idx(w_vb))) begin
      w_fr   = w_a;
      w_to   = w_b;
      w_disk = top_idx(w_va);
    end else begin
      w_fr   = w_b;
      w_to   = w_a;
      w_disk = top_idx(w_vb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r0   <= ALL;
      r_r1   <= '0;
      r_r2   <= '0;
      r_fr   <= '0;
      r_to   <= '0;
      r_disk <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_r0  <= ALL;
      r_r1  <= '0;
      r_r2  <= '0;
      r_cnt <= '0;
    end else if (w_calc) begin
      r_fr   <= w_fr;
      r_to   <= w_to;
      r_disk <= w_disk;
    end else if (w_hs) begin
      if (r_fr == 2'd0) r_r0 <= r_r0 & ~w_mask;
      if (r_fr == 2'd1) r_r1 <= r_r1 & ~w_mask;
      if (r_fr == 2'd2) r_r2 <= r_r2 & ~w_mask;
      if (r_to == 2'd0) r_r0 <= r_r0 | w_mask;
      if (r_to == 2'd1) r_r1 <= r_r1 | w_mask;
      if (r_to == 2'd2) r_r2 <= r_r2 | w_mask;
      r_cnt <= r_cnt + ONE;
    end
  end

  assign fr       = r_fr;
  assign to       = r_to;
  assign disk     = r_disk;
  assign move_cnt = r_cnt;

`ifdef HANOI_MOVEGEN_SVA_EN
  logic [S-1:0] w_src, w_dst, w_le;
  assign w_src = (r_fr == 2'd0) ? r_r0 : (r_fr == 2'd1) ? r_r1 : r_r2;
  assign w_dst = (r_to == 2'd0) ? r_r0 : (r_to == 2'd1) ? r_r1 : r_r2;
  assign w_le  = (w_mask << 1) - ONE;

  a_enc: assert property (@(posedge clk) disable iff (rst)
    fr != 2'b11 && to != 2'b11);
  a_ne: assert property (@(posedge clk) disable iff (rst)
    move_valid |-> fr != to);
  a_stb: assert property (@(posedge clk) disable iff (rst)
    move_valid && !move_ready |=>
      $stable(fr) && $stable(to) && $stable(disk));
  a_sz: assert property (@(posedge clk) disable iff (rst)
    move_valid |-> (w_dst & w_le) == '0);
  a_src: assert property (@(posedge clk) disable iff (rst)
    move_valid |-> (w_src & w_mask) != '0);
  a_cnt: assert property (@(posedge clk) disable iff (rst)
    r_cnt <= ALL);
  c_done: cover property (@(posedge clk) disable iff (rst)
    done && r_r2 == ALL);
`endif

endmodule

// File: tb/tb_hanoi_move_gen.sv
// Bench for hanoi_move_gen: S=4 and S=3 instances, scoreboard of expected moves.
module tb_hanoi_move_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_c = 1'b0;
  logic rdy = 1'b0;
  logic sel3 = 1'b0;

  logic       v4, busy4, done4;
  logic [1:0] fr4, to4, dk4;
  logic [3:0] cnt4;
  logic       v3, busy3, done3;
  logic [1:0] fr3, to3, dk3;
  logic [2:0] cnt3;

  logic       o_v, o_busy, o_done;
  logic [1:0] o_fr, o_to, o_dk;
  logic [7:0] o_cnt;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  logic [5:0] seen[0:15];

  always #5 clk = ~clk;

  hanoi_move_gen #(.S(4)) u4 (
    .clk(clk), .rst(rst),
    .start(start_c & ~sel3), .move_ready(rdy & ~sel3),
    .move_valid(v4), .fr(fr4), .to(to4), .disk(dk4),
    .move_cnt(cnt4), .busy(busy4), .done(done4)
  );

  hanoi_move_gen #(.S(3)) u3 (
    .clk(clk), .rst(rst),
    .start(start_c & sel3), .move_ready(rdy & sel3),
    .move_valid(v3), .fr(fr3), .to(to3), .disk(dk3),
    .move_cnt(cnt3), .busy(busy3), .done(done3)
  );

  always_comb begin
    o_v    = sel3 ? v3 : v4;
    o_busy = sel3 ? busy3 : busy4;
    o_done = sel3 ? done3 : done4;
    o_fr   = sel3 ? fr3 : fr4;
    o_to   = sel3 ? to3 : to4;
    o_dk   = sel3 ? dk3 : dk4;
    o_cnt  = sel3 ? {5'd0, cnt3} : {4'd0, cnt4};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Closed-form optimal move m (1-based); pegs 1/2 swap for even disk counts.
  function automatic logic [7:0] ref_move(input int s, input int m);
    int f, t, d;
    f = (m & (m - 1)) % 3;
    t = ((m | (m - 1)) + 1) % 3;
    if (s % 2 == 0) begin
      f = (f == 0) ? 0 : 3 - f;
      t = (t == 0) ? 0 : 3 - t;
    end
    d = 0;
    while (((m >> d) & 1) == 0) d++;
    return {f[1:0], t[1:0], d[3:0]};
  endfunction

  task automatic push(input int s, input int lo, input int hi);
    for (int m = lo; m <= hi; m++) sb.push_back(ref_move(s, m));
  endtask

  task automatic pulse_start();
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 10 && !o_v; t++) @(negedge clk);
    chk("valid_wait", o_v, 1);
  endtask

  task automatic accept(input int n);
    logic [7:0] e;
    rdy = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_valid();
      e = (sb.size() > 0) ? sb.pop_front() : 8'hff;
      chk("fr", o_fr, e[7:6]);
      chk("to", o_to, e[5:4]);
      chk("disk", o_dk, e[3:0]);
      seen[o_cnt[3:0]] = {o_fr, o_to, o_dk};
      @(negedge clk);
    end
    rdy = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", v4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_cnt", cnt4, 0);
    chk("rst_mv", {fr4, to4, dk4}, 0);
    chk("rst_cnt3", cnt3, 0);
    rst = 1'b0;
    @(negedge clk);

    pulse_start();
    chk("lat_valid", o_v, 0);
    chk("lat_busy", o_busy, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_valid", o_v, 1);
      chk("stall_mv", {o_fr, o_to, o_dk}, {2'd0, 2'd1, 2'd0});
      chk("stall_cnt", o_cnt, 0);
    end
    push(4, 1, 15);
    accept(5);
    chk("cnt5", o_cnt, 5);
    pulse_start();
    chk("ign_busy", o_busy, 1);
    chk("ign_cnt", o_cnt, 5);
    accept(10);
    chk("mv6", seen[5], {2'd2, 2'd1, 2'd1});
    chk("mv8", seen[7], {2'd0, 2'd2, 2'd3});
    chk("done", o_done, 1);
    chk("done_cnt", o_cnt, 15);
    chk("done_valid", o_v, 0);
    chk("done_busy", o_busy, 0);
    chk("done_mv", {o_fr, o_to, o_dk}, {2'd1, 2'd2, 2'd0});

    pulse_start();
    chk("re_done", o_done, 0);
    chk("re_cnt", o_cnt, 0);
    chk("re_valid", o_v, 0);
    push(4, 1, 15);
    accept(8);
    wait_valid();
    chk("m9_cnt", o_cnt, 8);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", o_v, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_cnt", o_cnt, 0);
    chk("mrst_done", o_done, 0);
    rst = 1'b0;
    sb.delete();
    pulse_start();
    push(4, 1, 3);
    accept(3);

    sel3 = 1'b1;
    @(negedge clk);
    pulse_start();
    push(3, 1, 7);
    accept(7);
    chk("s3_done", o_done, 1);
    chk("s3_cnt", o_cnt, 7);
    chk("s3_left", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
